// File: rtl/alu_op_sequencer.sv
// Hardwired fetch/decode/execute control sequencer for the 32-bit bus datapath.
// Runs one register-register ALU, multiply or divide instruction per accepted start.
module alu_op_sequencer #(
    parameter bit PC_INC_EN = 1'b1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic        mem_ready,
    input  logic [31:0] ir,
    output logic [15:0] Rout,
    output logic [15:0] Rin,
    output logic        PCout,
    output logic        MDRout,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        PCin,
    output logic        MARin,
    output logic        IRin,
    output logic        MDRin,
    output logic        Yin,
    output logic        Zin,
    output logic        LOin,
    output logic        HIin,
    output logic        MDRRead,
    output logic        mem_read,
    output logic        IncPC,
    output logic [11:0] ALUControl,
    output logic        busy,
    output logic        done,
    output logic        illegal
);

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        T0   = 4'd1,
        T1   = 4'd2,
        T2   = 4'd3,
        T3   = 4'd4,
        T4   = 4'd5,
        T5   = 4'd6,
        T6   = 4'd7,
        ILL  = 4'd8
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [4:0]  opcode;
    logic [15:0] ra_sel;
    logic [15:0] rb_sel;
    logic [15:0] rc_sel;
    logic [11:0] alu_sel;
    logic        op_legal;
    logic        op_muldiv;

    // ir[14:0] carries no information for register-register instructions
    logic        unused_ir_low;
    assign unused_ir_low = ^ir[14:0];

    assign opcode = ir[31:27];
    assign ra_sel = 16'd1 << ir[26:23];
    assign rb_sel = 16'd1 << ir[22:19];
    assign rc_sel = 16'd1 << ir[18:15];

    // Opcode to one-hot ALU operation; an all-zero result marks an undefined opcode
    always_comb begin
        alu_sel = '0;
        case (opcode)
            OP_ADD:  alu_sel[0]  = 1'b1;
            OP_SUB:  alu_sel[1]  = 1'b1;
            OP_AND:  alu_sel[2]  = 1'b1;
            OP_OR:   alu_sel[3]  = 1'b1;
            OP_SHR:  alu_sel[4]  = 1'b1;
            OP_SHRA: alu_sel[5]  = 1'b1;
            OP_SHL:  alu_sel[6]  = 1'b1;
            OP_ROR:  alu_sel[7]  = 1'b1;
            OP_ROL:  alu_sel[8]  = 1'b1;
            OP_MUL:  alu_sel[9]  = 1'b1;
            OP_DIV:  alu_sel[10] = 1'b1;
            default: alu_sel     = '0;
        endcase
    end

    assign op_legal  = |alu_sel;
    assign op_muldiv = alu_sel[9] | alu_sel[10];

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        Rout       = '0;
        Rin        = '0;
        PCout      = 1'b0;
        MDRout     = 1'b0;
        Zlowout    = 1'b0;
        Zhighout   = 1'b0;
        PCin       = 1'b0;
        MARin      = 1'b0;
        IRin       = 1'b0;
        MDRin      = 1'b0;
        Yin        = 1'b0;
        Zin        = 1'b0;
        LOin       = 1'b0;
        HIin       = 1'b0;
        MDRRead    = 1'b0;
        mem_read   = 1'b0;
        IncPC      = 1'b0;
        ALUControl = '0;
        busy       = (state != IDLE);
        done       = 1'b0;
        illegal    = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = T0;
                end
            end
            T0: begin
                PCout      = 1'b1;
                MARin      = 1'b1;
                IncPC      = PC_INC_EN;
                Zin        = 1'b1;
                state_next = T1;
            end
            // Reloading PC while waiting is harmless: Zlow still holds PC+1
            T1: begin
                Zlowout  = 1'b1;
                PCin     = 1'b1;
                mem_read = 1'b1;
                MDRRead  = 1'b1;
                MDRin    = mem_ready;
                if (mem_ready) begin
                    state_next = T2;
                end
            end
            T2: begin
                MDRout     = 1'b1;
                IRin       = 1'b1;
                state_next = T3;
            end
            T3: begin
                if (op_legal) begin
                    Rout       = rb_sel;
                    Yin        = 1'b1;
                    state_next = T4;
                end else begin
                    state_next = ILL;
                end
            end
            T4: begin
                Rout       = rc_sel;
                ALUControl = alu_sel;
                Zin        = 1'b1;
                state_next = T5;
            end
            T5: begin
                Zlowout = 1'b1;
                if (op_muldiv) begin
                    LOin       = 1'b1;
                    state_next = T6;
                end else begin
                    Rin        = ra_sel;
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            T6: begin
                Zhighout   = 1'b1;
                HIin       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            ILL: begin
                illegal    = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The bus encoder tolerates only a single driver per cycle
    out_select_onehot: assert property (@(posedge clk)
        $onehot0({Rout, PCout, MDRout, Zlowout, Zhighout}));

    done_illegal_exclusive: assert property (@(posedge clk) !(done && illegal));

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: per-cycle control vectors from a
// state-table model plus a scoreboard of done/illegal completion cycles.
module tb_alu_op_sequencer;

    logic        clk;
    logic        clr;
    logic        start;
    logic        mem_ready;
    logic [31:0] ir;
    logic [15:0] Rout;
    logic [15:0] Rin;
    logic        PCout, MDRout, Zlowout, Zhighout;
    logic        PCin, MARin, IRin, MDRin, Yin, Zin, LOin, HIin;
    logic        MDRRead, mem_read, IncPC;
    logic [11:0] ALUControl;
    logic        busy, done, illegal;

    typedef struct packed {
        logic [15:0] rout;
        logic [15:0] rin;
        logic        pc_out;
        logic        mdr_out;
        logic        zlow_out;
        logic        zhigh_out;
        logic        pc_in;
        logic        mar_in;
        logic        ir_in;
        logic        mdr_in;
        logic        y_in;
        logic        z_in;
        logic        lo_in;
        logic        hi_in;
        logic        mdr_read;
        logic        mem_read;
        logic        inc_pc;
        logic [11:0] alu;
        logic        busy;
        logic        done;
        logic        illegal;
    } ctl_t;

    typedef struct {
        logic [31:0] ir;
        int          wait_cycles;
        logic [11:0] alu;
        logic [15:0] rb_sel;
        logic [15:0] rc_sel;
        logic [15:0] rin;
        bit          muldiv;
        bit          ill;
        int          end_cyc;
    } vec_t;

    typedef struct {
        int cyc;
        bit ill;
    } sb_t;

    ctl_t  dut_ctl;
    vec_t  vecs [9];
    sb_t   sbq [$];
    int    checks;
    int    failures;
    int    cyc;

    alu_op_sequencer #(.PC_INC_EN(1'b1)) dut (
        .clk        (clk),
        .clr        (clr),
        .start      (start),
        .mem_ready  (mem_ready),
        .ir         (ir),
        .Rout       (Rout),
        .Rin        (Rin),
        .PCout      (PCout),
        .MDRout     (MDRout),
        .Zlowout    (Zlowout),
        .Zhighout   (Zhighout),
        .PCin       (PCin),
        .MARin      (MARin),
        .IRin       (IRin),
        .MDRin      (MDRin),
        .Yin        (Yin),
        .Zin        (Zin),
        .LOin       (LOin),
        .HIin       (HIin),
        .MDRRead    (MDRRead),
        .mem_read   (mem_read),
        .IncPC      (IncPC),
        .ALUControl (ALUControl),
        .busy       (busy),
        .done       (done),
        .illegal    (illegal)
    );

    assign dut_ctl = {Rout, Rin, PCout, MDRout, Zlowout, Zhighout, PCin, MARin, IRin,
                      MDRin, Yin, Zin, LOin, HIin, MDRRead, mem_read, IncPC,
                      ALUControl, busy, done, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected controls for cycle k after start was accepted (k=0 is the accepting IDLE cycle)
    function automatic ctl_t exp_ctl(input vec_t v, input int k, input logic mr);
        ctl_t e;
        int   w;
        e = '0;
        w = v.wait_cycles;
        if (k == 1) begin
            e.pc_out = 1'b1; e.mar_in = 1'b1; e.inc_pc = 1'b1; e.z_in = 1'b1; e.busy = 1'b1;
        end else if (k >= 2 && k <= w + 2) begin
            e.zlow_out = 1'b1; e.pc_in = 1'b1; e.mem_read = 1'b1; e.mdr_read = 1'b1;
            e.mdr_in = mr; e.busy = 1'b1;
        end else if (k == w + 3) begin
            e.mdr_out = 1'b1; e.ir_in = 1'b1; e.busy = 1'b1;
        end else if (k == w + 4) begin
            e.busy = 1'b1;
            if (!v.ill) begin
                e.rout = v.rb_sel; e.y_in = 1'b1;
            end
        end else if (k == w + 5) begin
            e.busy = 1'b1;
            if (v.ill) begin
                e.illegal = 1'b1;
            end else begin
                e.rout = v.rc_sel; e.alu = v.alu; e.z_in = 1'b1;
            end
        end else if (k == w + 6 && !v.ill) begin
            e.zlow_out = 1'b1; e.busy = 1'b1;
            if (v.muldiv) begin
                e.lo_in = 1'b1;
            end else begin
                e.rin = v.rin; e.done = 1'b1;
            end
        end else if (k == w + 7 && v.muldiv) begin
            e.zhigh_out = 1'b1; e.hi_in = 1'b1; e.done = 1'b1; e.busy = 1'b1;
        end
        return e;
    endfunction

    // One clock: drive inputs after the edge, then at the falling edge retire completions
    task automatic applyStimulus(input logic s, input logic mr, input logic [31:0] i,
                                 input logic c);
        sb_t e;
        @(posedge clk);
        #1;
        start     = s;
        mem_ready = mr;
        ir        = i;
        clr       = c;
        cyc++;
        @(negedge clk);
        if (dut_ctl.done || dut_ctl.illegal) begin
            checks++;
            if (sbq.size() == 0) begin
                failures++;
                $display("[TB] FAIL sb_unexpected cyc=%0d done=%0b illegal=%0b required=none",
                         cyc, dut_ctl.done, dut_ctl.illegal);
            end else begin
                e = sbq.pop_front();
                if (e.cyc != cyc || e.ill != dut_ctl.illegal) begin
                    failures++;
                    $display("[TB] FAIL sb_completion got cyc=%0d illegal=%0b required cyc=%0d illegal=%0b",
                             cyc, dut_ctl.illegal, e.cyc, e.ill);
                end
            end
        end
    endtask

    task automatic checkOutput(input string name, input int k, input ctl_t exp);
        checks++;
        if (dut_ctl !== exp) begin
            failures++;
            $display("[TB] FAIL %s k=%0d got=%h required=%h", name, k, dut_ctl, exp);
        end
    endtask

    task automatic set_vec(input int idx, input logic [31:0] i, input int w,
                           input logic [11:0] alu, input logic [15:0] rb,
                           input logic [15:0] rc, input logic [15:0] rin,
                           input bit md, input bit ill, input int endc);
        vecs[idx].ir          = i;
        vecs[idx].wait_cycles = w;
        vecs[idx].alu         = alu;
        vecs[idx].rb_sel      = rb;
        vecs[idx].rc_sel      = rc;
        vecs[idx].rin         = rin;
        vecs[idx].muldiv      = md;
        vecs[idx].ill         = ill;
        vecs[idx].end_cyc     = endc;
    endtask

    task automatic run_instr(input int idx);
        vec_t v;
        sb_t  e;
        int   last;
        logic mr;
        v = vecs[idx];
        applyStimulus(1'b1, 1'b1, v.ir, 1'b0);
        checkOutput($sformatf("vec%0d_accept", idx), 0, '0);
        e.cyc = cyc + v.end_cyc;
        e.ill = v.ill;
        sbq.push_back(e);
        last = v.ill ? v.wait_cycles + 5 : (v.muldiv ? v.wait_cycles + 7 : v.wait_cycles + 6);
        for (int k = 1; k <= last + 1; k++) begin
            mr = (k >= 2 && k < 2 + v.wait_cycles) ? 1'b0 : 1'b1;
            applyStimulus(1'b0, mr, v.ir, 1'b0);
            checkOutput($sformatf("vec%0d", idx), k, exp_ctl(v, k, mr));
        end
    endtask

    initial begin
        vec_t v;
        logic mr;
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        clr       = 1'b1;
        start     = 1'b0;
        mem_ready = 1'b0;
        ir        = '0;

        //          idx ir            w  alu     rb       rc       rin      md ill end
        set_vec(0, 32'h18918000, 0, 12'h001, 16'h0004, 16'h0008, 16'h0002, 0, 0, 6);
        set_vec(1, 32'h18918000, 3, 12'h001, 16'h0004, 16'h0008, 16'h0002, 0, 0, 9);
        set_vec(2, 32'h782B0000, 0, 12'h200, 16'h0020, 16'h0040, 16'h0000, 1, 0, 7);
        set_vec(3, 32'hF8000000, 0, 12'h000, 16'h0000, 16'h0000, 16'h0000, 0, 1, 5);
        set_vec(4, 32'h27878000, 0, 12'h002, 16'h0001, 16'h8000, 16'h8000, 0, 0, 6);
        set_vec(5, 32'h583B8000, 1, 12'h100, 16'h0080, 16'h0080, 16'h0001, 0, 0, 7);
        set_vec(6, 32'h81C90000, 2, 12'h400, 16'h0200, 16'h0004, 16'h0000, 1, 0, 9);
        set_vec(7, 32'h61234567, 0, 12'h000, 16'h0000, 16'h0000, 16'h0000, 0, 1, 5);
        set_vec(8, 32'h88000000, 1, 12'h000, 16'h0000, 16'h0000, 16'h0000, 0, 1, 6);

        applyStimulus(1'b0, 1'b1, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("reset", 0, '0);

        for (int i = 0; i < 9; i++) begin
            run_instr(i);
        end

        // Reset while T4 is active: the Ra write must never happen
        v = vecs[0];
        applyStimulus(1'b1, 1'b1, v.ir, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            applyStimulus(1'b0, 1'b1, v.ir, (k == 5));
            checkOutput("clr_t4", k, (k <= 5) ? exp_ctl(v, k, 1'b1) : ctl_t'('0));
        end

        // Reset during a memory wait in T1
        v = vecs[1];
        applyStimulus(1'b1, 1'b1, v.ir, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            mr = (k == 2 || k == 3) ? 1'b0 : 1'b1;
            applyStimulus(1'b0, mr, v.ir, (k == 3));
            checkOutput("clr_t1", k, (k <= 3) ? exp_ctl(v, k, mr) : ctl_t'('0));
        end

        // start held high: ignored while busy, re-accepted after one IDLE cycle
        v = vecs[0];
        applyStimulus(1'b1, 1'b1, v.ir, 1'b0);
        begin
            sb_t e;
            e.ill = 1'b0;
            e.cyc = cyc + 6;
            sbq.push_back(e);
            e.cyc = cyc + 13;
            sbq.push_back(e);
        end
        for (int k = 1; k <= 14; k++) begin
            applyStimulus((k <= 7), 1'b1, v.ir, 1'b0);
            if (k <= 6) begin
                checkOutput("start_held", k, exp_ctl(v, k, 1'b1));
            end else if (k == 7) begin
                checkOutput("start_held_idle", k, '0);
            end else begin
                checkOutput("start_held", k, exp_ctl(v, k - 7, 1'b1));
            end
        end

        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("[TB] FAIL sb_drain got pending=%0d required=0", sbq.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
